// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: turns a 32-bit big-endian word stream into 16-word
// padded blocks (0x80 marker, zero fill, 64-bit bit length) emitted word-serially.
module sha256_msg_padder #(
  parameter int LEN_W = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  input  logic        in_last,
  input  logic [2:0]  in_bytes,
  output logic        blk_valid,
  input  logic        blk_ready,
  output logic [31:0] blk_word,
  output logic [3:0]  blk_idx,
  output logic        blk_sof,
  output logic        blk_last
);

  typedef enum logic [2:0] {DATA, PAD, ZERO, LEN_HI, LEN_LO} state_t;

  state_t           state;
  logic [3:0]       idx;
  logic [LEN_W-1:0] len;
  logic             sof_pending;

  logic [63:0]      len_ext;
  logic [3:0]       idx_next;
  logic             xfer;
  logic             short_last;

  // Final partial word: keep the valid leading bytes and place the 0x80 marker right after them.
  function automatic logic [31:0] pad_last_word(input logic [31:0] w, input logic [2:0] nb);
    case (nb)
      3'd0:    pad_last_word = 32'h8000_0000;
      3'd1:    pad_last_word = {w[31:24], 24'h80_0000};
      3'd2:    pad_last_word = {w[31:16], 16'h8000};
      3'd3:    pad_last_word = {w[31:8], 8'h80};
      default: pad_last_word = w;
    endcase
  endfunction

  function automatic logic [LEN_W-1:0] byte_bits(input logic [2:0] nb);
    byte_bits = LEN_W'({nb, 3'b000});
  endfunction

  assign len_ext    = 64'(len);
  assign idx_next   = idx + 4'd1;
  assign xfer       = blk_valid & blk_ready;
  assign short_last = in_last & (in_bytes < 3'd4);

  // DATA passes the upstream handshake straight through; padding states self-drive.
  always_comb begin
    blk_valid = 1'b0;
    in_ready  = 1'b0;
    blk_word  = 32'h0;
    blk_last  = 1'b0;
    if (rst_n) begin
      case (state)
        DATA: begin
          blk_valid = in_valid;
          in_ready  = blk_ready;
          blk_word  = in_last ? pad_last_word(in_word, in_bytes) : in_word;
        end
        PAD: begin
          blk_valid = 1'b1;
          blk_word  = 32'h8000_0000;
        end
        ZERO: begin
          blk_valid = 1'b1;
        end
        LEN_HI: begin
          blk_valid = 1'b1;
          blk_word  = len_ext[63:32];
        end
        LEN_LO: begin
          blk_valid = 1'b1;
          blk_word  = len_ext[31:0];
          blk_last  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign blk_idx = rst_n ? idx : 4'd0;
  assign blk_sof = sof_pending & blk_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= DATA;
      idx         <= 4'd0;
      len         <= '0;
      sof_pending <= 1'b1;
    end else if (xfer) begin
      idx         <= idx_next;
      sof_pending <= 1'b0;
      case (state)
        DATA: begin
          if (short_last) begin
            len   <= len + byte_bits(in_bytes);
            state <= (idx_next == 4'd14) ? LEN_HI : ZERO;
          end else begin
            len <= len + LEN_W'(32);
            if (in_last) state <= PAD;
          end
        end
        // Padding that lands on idx 14/15 runs on through a whole extra block.
        PAD, ZERO: state <= (idx_next == 4'd14) ? LEN_HI : ZERO;
        LEN_HI:    state <= LEN_LO;
        LEN_LO: begin
          len         <= '0;
          sof_pending <= 1'b1;
          state       <= DATA;
        end
        default:   state <= DATA;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: hand-computed padded blocks per scenario.
module tb_sha256_msg_padder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_word = 32'h0;
  logic        in_last = 1'b0;
  logic [2:0]  in_bytes = 3'd0;
  logic        blk_valid;
  logic        blk_ready = 1'b1;
  logic [31:0] blk_word;
  logic [3:0]  blk_idx;
  logic        blk_sof;
  logic        blk_last;

  int checks = 0;
  int failures = 0;

  sha256_msg_padder #(.LEN_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .in_last(in_last), .in_bytes(in_bytes),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_word(blk_word),
    .blk_idx(blk_idx), .blk_sof(blk_sof), .blk_last(blk_last)
  );

  always #5 clk = ~clk;

  // Transfer recorder
  logic [31:0] cap_word [0:511];
  logic [3:0]  cap_idx  [0:511];
  logic        cap_sof  [0:511];
  logic        cap_last [0:511];
  int          cap_cyc  [0:511];
  int          cap_n = 0;
  int          cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && blk_valid && blk_ready && cap_n < 512) begin
      cap_word[cap_n] <= blk_word;
      cap_idx[cap_n]  <= blk_idx;
      cap_sof[cap_n]  <= blk_sof;
      cap_last[cap_n] <= blk_last;
      cap_cyc[cap_n]  <= cyc;
      cap_n           <= cap_n + 1;
    end
  end

  task automatic send_word(input logic [31:0] w, input logic last, input logic [2:0] nb);
    int t = 0;
    in_valid = 1'b1; in_word = w; in_last = last; in_bytes = nb;
    @(negedge clk);
    while (!in_ready && t < 300) begin @(negedge clk); t++; end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout got in_ready=%b exp 1 word=%h", in_ready, w);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_caps(input int target);
    int t = 0;
    while (cap_n < target && t < 300) begin @(negedge clk); t++; end
    checks++;
    if (cap_n < target) begin
      failures++;
      $display("FAIL out_timeout got=%0d exp=%0d transfers", cap_n, target);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_word = 32'h1234_5678; blk_ready = 1'b1;
    #12;
    checks++; if (blk_valid !== 1'b0) begin failures++; $display("FAIL rst_blk_valid got=%b exp=0", blk_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    checks++; if (blk_word !== 32'h0) begin failures++; $display("FAIL rst_blk_word got=%h exp=0", blk_word); end
    checks++; if (blk_idx !== 4'd0) begin failures++; $display("FAIL rst_blk_idx got=%0d exp=0", blk_idx); end
    checks++; if (blk_sof !== 1'b0 || blk_last !== 1'b0) begin failures++; $display("FAIL rst_sof_last got=%b%b exp=00", blk_sof, blk_last); end
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_abc();
    logic [31:0] ew [32];
    int s = cap_n;
    foreach (ew[i]) ew[i] = 32'h0;
    ew[0] = 32'h6162_6380; ew[15] = 32'h0000_0018;
    send_word(32'h6162_6300, 1'b1, 3'd3);
    wait_caps(s + 16);
    for (int k = 0; k < 16; k++) begin
      checks++; if (cap_word[s+k] !== ew[k]) begin failures++; $display("FAIL abc_word[%0d] got=%h exp=%h", k, cap_word[s+k], ew[k]); end
      checks++; if (cap_idx[s+k] !== 4'(k)) begin failures++; $display("FAIL abc_idx[%0d] got=%0d exp=%0d", k, cap_idx[s+k], k); end
      checks++; if (cap_sof[s+k] !== (k == 0)) begin failures++; $display("FAIL abc_sof[%0d] got=%b", k, cap_sof[s+k]); end
      checks++; if (cap_last[s+k] !== (k == 15)) begin failures++; $display("FAIL abc_last[%0d] got=%b", k, cap_last[s+k]); end
    end
    checks++; if (cap_n !== s + 16) begin failures++; $display("FAIL abc_count got=%0d exp=%0d", cap_n - s, 16); end
  endtask

  task automatic test_full_word();
    logic [31:0] ew [32];
    int s = cap_n;
    foreach (ew[i]) ew[i] = 32'h0;
    ew[0] = 32'h6162_6364; ew[1] = 32'h8000_0000; ew[15] = 32'h0000_0020;
    send_word(32'h6162_6364, 1'b1, 3'd4);
    wait_caps(s + 16);
    for (int k = 0; k < 16; k++) begin
      checks++; if (cap_word[s+k] !== ew[k]) begin failures++; $display("FAIL full_word[%0d] got=%h exp=%h", k, cap_word[s+k], ew[k]); end
      checks++; if (cap_idx[s+k] !== 4'(k)) begin failures++; $display("FAIL full_idx[%0d] got=%0d exp=%0d", k, cap_idx[s+k], k); end
      checks++; if (cap_last[s+k] !== (k == 15)) begin failures++; $display("FAIL full_last[%0d] got=%b", k, cap_last[s+k]); end
    end
    checks++; if (cap_n !== s + 16) begin failures++; $display("FAIL full_count got=%0d exp=%0d", cap_n - s, 16); end
  endtask

  task automatic test_pad_at_14();
    logic [31:0] ew [32];
    int s = cap_n;
    foreach (ew[i]) ew[i] = 32'h0;
    for (int i = 0; i < 14; i++) ew[i] = 32'hA500_0000 + 32'(i);
    ew[14] = 32'h8000_0000; ew[31] = 32'h0000_01C0;
    for (int i = 0; i < 14; i++) send_word(32'hA500_0000 + 32'(i), (i == 13), 3'd4);
    wait_caps(s + 32);
    for (int k = 0; k < 32; k++) begin
      checks++; if (cap_word[s+k] !== ew[k]) begin failures++; $display("FAIL pad14_word[%0d] got=%h exp=%h", k, cap_word[s+k], ew[k]); end
      checks++; if (cap_idx[s+k] !== 4'(k % 16)) begin failures++; $display("FAIL pad14_idx[%0d] got=%0d exp=%0d", k, cap_idx[s+k], k % 16); end
      checks++; if (cap_sof[s+k] !== (k == 0)) begin failures++; $display("FAIL pad14_sof[%0d] got=%b", k, cap_sof[s+k]); end
      checks++; if (cap_last[s+k] !== (k == 31)) begin failures++; $display("FAIL pad14_last[%0d] got=%b", k, cap_last[s+k]); end
    end
    checks++; if (cap_cyc[s+31] - cap_cyc[s] !== 31) begin failures++; $display("FAIL pad14_rate got=%0d exp=31 cycles", cap_cyc[s+31] - cap_cyc[s]); end
    checks++; if (cap_n !== s + 32) begin failures++; $display("FAIL pad14_count got=%0d exp=%0d", cap_n - s, 32); end
  endtask

  task automatic test_empty();
    logic [31:0] ew [32];
    int s = cap_n;
    foreach (ew[i]) ew[i] = 32'h0;
    ew[0] = 32'h8000_0000;
    send_word(32'hDEAD_BEEF, 1'b1, 3'd0);
    wait_caps(s + 16);
    for (int k = 0; k < 16; k++) begin
      checks++; if (cap_word[s+k] !== ew[k]) begin failures++; $display("FAIL empty_word[%0d] got=%h exp=%h", k, cap_word[s+k], ew[k]); end
      checks++; if (cap_last[s+k] !== (k == 15)) begin failures++; $display("FAIL empty_last[%0d] got=%b", k, cap_last[s+k]); end
    end
  endtask

  task automatic test_len_at_13();
    logic [31:0] ew [32];
    int s = cap_n;
    foreach (ew[i]) ew[i] = 32'h0;
    for (int i = 0; i < 13; i++) ew[i] = 32'h0102_0300 + 32'(i);
    ew[13] = 32'h7780_0000; ew[15] = 32'h0000_01A8;
    for (int i = 0; i < 13; i++) send_word(32'h0102_0300 + 32'(i), 1'b0, 3'd4);
    send_word(32'h7766_5544, 1'b1, 3'd1);
    wait_caps(s + 16);
    for (int k = 0; k < 16; k++) begin
      checks++; if (cap_word[s+k] !== ew[k]) begin failures++; $display("FAIL len13_word[%0d] got=%h exp=%h", k, cap_word[s+k], ew[k]); end
      checks++; if (cap_last[s+k] !== (k == 15)) begin failures++; $display("FAIL len13_last[%0d] got=%b", k, cap_last[s+k]); end
    end
    checks++; if (cap_n !== s + 16) begin failures++; $display("FAIL len13_count got=%0d exp=%0d", cap_n - s, 16); end
  endtask

  task automatic test_backpressure();
    logic [31:0] ew [32];
    int s = cap_n;
    foreach (ew[i]) ew[i] = 32'h0;
    for (int i = 0; i < 6; i++) ew[i] = 32'h1000_0000 + 32'(i);
    ew[6] = 32'hAABB_8000; ew[15] = 32'h0000_00D0;
    fork
      begin
        for (int i = 0; i < 6; i++) send_word(32'h1000_0000 + 32'(i), 1'b0, 3'd4);
        send_word(32'hAABB_CCDD, 1'b1, 3'd2);
      end
      begin
        logic d5 = 1'b0, d9 = 1'b0;
        logic [31:0] hw; logic [3:0] hi;
        int t = 0;
        while (!(d5 && d9) && t < 100) begin
          @(posedge clk); #2; t++;
          if (blk_valid && ((blk_idx == 4'd5 && !d5) || (blk_idx == 4'd9 && !d9))) begin
            if (blk_idx == 4'd5) d5 = 1'b1; else d9 = 1'b1;
            hw = blk_word; hi = blk_idx;
            blk_ready = 1'b0;
            repeat (3) begin
              @(negedge clk);
              checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0 idx=%0d", in_ready, hi); end
              checks++; if (blk_word !== hw || blk_idx !== hi) begin failures++; $display("FAIL bp_hold got=%h/%0d exp=%h/%0d", blk_word, blk_idx, hw, hi); end
            end
            @(posedge clk); #2;
            blk_ready = 1'b1;
          end
        end
        checks++; if (!(d5 && d9)) begin failures++; $display("FAIL bp_stalls got=%b%b exp=11", d5, d9); end
      end
    join
    wait_caps(s + 16);
    for (int k = 0; k < 16; k++) begin
      checks++; if (cap_word[s+k] !== ew[k]) begin failures++; $display("FAIL bp_word[%0d] got=%h exp=%h", k, cap_word[s+k], ew[k]); end
      checks++; if (cap_idx[s+k] !== 4'(k)) begin failures++; $display("FAIL bp_idx[%0d] got=%0d exp=%0d", k, cap_idx[s+k], k); end
    end
    checks++; if (cap_n !== s + 16) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", cap_n - s, 16); end
  endtask

  task automatic test_async_reset();
    int s, t = 0;
    send_word(32'h6162_6300, 1'b1, 3'd3);
    @(negedge clk);
    while (!(blk_valid && blk_idx == 4'd9) && t < 100) begin @(negedge clk); t++; end
    checks++; if (!(blk_valid && blk_idx == 4'd9)) begin failures++; $display("FAIL ar_reach_idx9 got=%0d exp=9", blk_idx); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (blk_valid !== 1'b0) begin failures++; $display("FAIL ar_blk_valid got=%b exp=0", blk_valid); end
    checks++; if (blk_idx !== 4'd0) begin failures++; $display("FAIL ar_blk_idx got=%0d exp=0", blk_idx); end
    checks++; if (blk_word !== 32'h0 || in_ready !== 1'b0) begin failures++; $display("FAIL ar_outputs got=%h/%b exp=0/0", blk_word, in_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    s = cap_n;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (cap_n !== s) begin failures++; $display("FAIL ar_leftover got=%0d exp=0 transfers", cap_n - s); end
    send_word(32'h6162_6300, 1'b1, 3'd3);
    wait_caps(s + 16);
    checks++; if (cap_word[s] !== 32'h6162_6380 || cap_idx[s] !== 4'd0) begin failures++; $display("FAIL ar_first got=%h/%0d exp=61626380/0", cap_word[s], cap_idx[s]); end
    checks++; if (cap_sof[s] !== 1'b1) begin failures++; $display("FAIL ar_sof got=%b exp=1", cap_sof[s]); end
    checks++; if (cap_word[s+15] !== 32'h0000_0018 || cap_last[s+15] !== 1'b1) begin failures++; $display("FAIL ar_len got=%h/%b exp=00000018/1", cap_word[s+15], cap_last[s+15]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ew [32];
    int s = cap_n;
    foreach (ew[i]) ew[i] = 32'h0;
    ew[0] = 32'h6162_6380; ew[15] = 32'h0000_0018;
    ew[16] = 32'h6162_6364; ew[17] = 32'h8000_0000; ew[31] = 32'h0000_0020;
    send_word(32'h6162_6300, 1'b1, 3'd3);
    send_word(32'h6162_6364, 1'b1, 3'd4);
    wait_caps(s + 32);
    for (int k = 0; k < 32; k++) begin
      checks++; if (cap_word[s+k] !== ew[k]) begin failures++; $display("FAIL b2b_word[%0d] got=%h exp=%h", k, cap_word[s+k], ew[k]); end
      checks++; if (cap_sof[s+k] !== (k == 0 || k == 16)) begin failures++; $display("FAIL b2b_sof[%0d] got=%b", k, cap_sof[s+k]); end
      checks++; if (cap_last[s+k] !== (k == 15 || k == 31)) begin failures++; $display("FAIL b2b_last[%0d] got=%b", k, cap_last[s+k]); end
    end
    checks++; if (cap_cyc[s+31] - cap_cyc[s] !== 31) begin failures++; $display("FAIL b2b_rate got=%0d exp=31 cycles", cap_cyc[s+31] - cap_cyc[s]); end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_full_word();
    test_pad_at_14();
    test_empty();
    test_len_at_13();
    test_backpressure();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
